// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller.
// Sequences FETCH/DECODE/EXEC/MEM/WB for one instruction at a time, decodes
// opcode/funct into datapath controls, counts retired instructions and keeps
// a sticky flag for unsupported encodings.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       npc_sel,
  output logic [1:0]       extop,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_wr,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  // State encoding is visible on the state port, so it stays fixed.
  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JT   = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_alu_wb, is_jump, supported;

  logic retire_c;
  logic pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c;

  // Instruction decode from the (stable) IR fields.
  always_comb begin
    is_addu   = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    is_subu   = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);
    is_ori    = (opcode == OP_ORI);
    is_lui    = (opcode == OP_LUI);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_beq    = (opcode == OP_BEQ);
    is_j      = (opcode == OP_J);
    is_jal    = (opcode == OP_JAL);
    is_alu_wb = is_addu | is_subu | is_ori | is_lui;
    is_jump   = is_beq | is_j | is_jal | is_jr;
    supported = is_alu_wb | is_lw | is_sw | is_jump;
  end

  // Next-state, retire pulse and sticky illegal-instruction flag.
  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (supported) begin
          state_d = S_EXEC;
        end else begin
          // Unsupported encodings retire here as a 2-cycle nop.
          state_d   = S_FETCH;
          illegal_d = 1'b1;
          retire_c  = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_alu_wb) begin
          state_d = S_WB;
        end else begin
          state_d  = S_FETCH;
          retire_c = is_jump;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          state_d = S_WB;
        end else begin
          state_d  = S_FETCH;
          retire_c = is_sw;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(retire_c);
  end

  // Datapath controls; write enables are masked while reset is high.
  always_comb begin
    pc_wr_c  = 1'b0;
    ir_wr_c  = 1'b0;
    reg_wr_c = 1'b0;
    mem_wr_c = 1'b0;
    npc_sel  = NPC_PC4;
    extop    = EXT_ZERO;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    reg_dst  = DST_RT;
    wd_sel   = WD_ALU;
    case (state_q)
      S_FETCH: begin
        ir_wr_c = 1'b1;
        pc_wr_c = 1'b1;
        npc_sel = NPC_PC4;
      end
      S_DECODE: begin
      end
      S_EXEC: begin
        if (is_addu) begin
          alu_op = ALU_ADD;
        end else if (is_subu) begin
          alu_op = ALU_SUB;
        end else if (is_ori) begin
          extop   = EXT_ZERO;
          alu_src = 1'b1;
          alu_op  = ALU_OR;
        end else if (is_lui) begin
          extop   = EXT_HI;
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
        end else if (is_lw || is_sw) begin
          extop   = EXT_SIGN;
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
        end else if (is_beq) begin
          extop   = EXT_SIGN;
          alu_op  = ALU_SUB;
          npc_sel = NPC_BR;
          pc_wr_c = zero;
        end else if (is_j) begin
          npc_sel = NPC_JT;
          pc_wr_c = 1'b1;
        end else if (is_jal) begin
          npc_sel  = NPC_JT;
          pc_wr_c  = 1'b1;
          reg_wr_c = 1'b1;
          reg_dst  = DST_RA;
          wd_sel   = WD_PC4;
        end else if (is_jr) begin
          npc_sel = NPC_RS;
          pc_wr_c = 1'b1;
        end
      end
      S_MEM: begin
        if (is_lw || is_sw) begin
          extop = EXT_SIGN;
        end
        mem_wr_c = is_sw;
      end
      S_WB: begin
        reg_wr_c = 1'b1;
        if (is_addu || is_subu) begin
          reg_dst = DST_RD;
          wd_sel  = WD_ALU;
          alu_op  = is_subu ? ALU_SUB : ALU_ADD;
        end else if (is_ori) begin
          reg_dst = DST_RT;
          wd_sel  = WD_ALU;
          extop   = EXT_ZERO;
          alu_src = 1'b1;
          alu_op  = ALU_OR;
        end else if (is_lui) begin
          reg_dst = DST_RT;
          wd_sel  = WD_ALU;
          extop   = EXT_HI;
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
        end else if (is_lw) begin
          reg_dst = DST_RT;
          wd_sel  = WD_DM;
          extop   = EXT_SIGN;
        end
      end
      default: begin
      end
    endcase

    pc_wr  = pc_wr_c  & ~reset;
    ir_wr  = ir_wr_c  & ~reset;
    reg_wr = reg_wr_c & ~reset;
    mem_wr = mem_wr_c & ~reset;
    retire = retire_c & ~reset;
  end

  // State, counter and sticky flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle tables model the
// expected control outputs; random instruction streams exercise all paths.
module tb_mc_ctrl;

  localparam int unsigned CW = 4;

  localparam int K_ADDU = 0;
  localparam int K_SUBU = 1;
  localparam int K_JR   = 2;
  localparam int K_ORI  = 3;
  localparam int K_LUI  = 4;
  localparam int K_LW   = 5;
  localparam int K_SW   = 6;
  localparam int K_BEQ  = 7;
  localparam int K_J    = 8;
  localparam int K_JAL  = 9;
  localparam int K_ILL  = 10;

  typedef struct packed {
    logic [2:0]    state;
    logic          pc_wr;
    logic          ir_wr;
    logic [1:0]    npc_sel;
    logic [1:0]    extop;
    logic          alu_src;
    logic [2:0]    alu_op;
    logic          reg_wr;
    logic [1:0]    reg_dst;
    logic [1:0]    wd_sel;
    logic          mem_wr;
    logic          retire;
    logic          illegal;
    logic [CW-1:0] cnt;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          pc_wr, ir_wr, alu_src, reg_wr, mem_wr, retire, illegal;
  logic [1:0]    npc_sel, extop, reg_dst, wd_sel;
  logic [2:0]    alu_op, state;
  logic [CW-1:0] instr_cnt;

  int tests = 0;
  int fails = 0;

  int unsigned model_cnt = 0;
  bit          model_ill = 1'b0;

  obs_t got  [5];
  obs_t want [5];
  int   nlat;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel), .extop(extop),
    .alu_src(alu_src), .alu_op(alu_op), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .mem_wr(mem_wr), .state(state), .retire(retire),
    .instr_cnt(instr_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    obs_t o;
    o.state   = state;   o.pc_wr   = pc_wr;   o.ir_wr  = ir_wr;
    o.npc_sel = npc_sel; o.extop   = extop;   o.alu_src = alu_src;
    o.alu_op  = alu_op;  o.reg_wr  = reg_wr;  o.reg_dst = reg_dst;
    o.wd_sel  = wd_sel;  o.mem_wr  = mem_wr;  o.retire = retire;
    o.illegal = illegal; o.cnt     = instr_cnt;
    return o;
  endfunction

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) return K_ADDU;
        if (fn == 6'b100011) return K_SUBU;
        if (fn == 6'b001000) return K_JR;
        return K_ILL;
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // Phase letters of each instruction class, one per clock cycle.
  function automatic string phases_of(int kind);
    case (kind)
      K_ADDU, K_SUBU, K_ORI, K_LUI: return "FDEW";
      K_LW:  return "FDEMW";
      K_SW:  return "FDEM";
      K_ILL: return "FD";
      default: return "FDE";
    endcase
  endfunction

  function automatic obs_t model_cycle(int kind, int k, bit z);
    obs_t  e;
    string seq;
    byte   ph;
    seq = phases_of(kind);
    ph  = seq[k];
    e = '0;
    e.cnt     = CW'(model_cnt);
    e.illegal = model_ill;
    e.retire  = (k == seq.len() - 1);
    case (ph)
      "F": begin e.state = 3'd0; e.ir_wr = 1'b1; e.pc_wr = 1'b1; end
      "D": e.state = 3'd1;
      "E": begin
        e.state = 3'd2;
        case (kind)
          K_SUBU: e.alu_op = 3'd1;
          K_ORI:  begin e.alu_src = 1'b1; e.alu_op = 3'd2; end
          K_LUI:  begin e.extop = 2'd2; e.alu_src = 1'b1; end
          K_LW, K_SW: begin e.extop = 2'd1; e.alu_src = 1'b1; end
          K_BEQ:  begin e.extop = 2'd1; e.alu_op = 3'd1; e.npc_sel = 2'd1; e.pc_wr = z; end
          K_J:    begin e.npc_sel = 2'd2; e.pc_wr = 1'b1; end
          K_JAL:  begin e.npc_sel = 2'd2; e.pc_wr = 1'b1; e.reg_wr = 1'b1;
                        e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
          K_JR:   begin e.npc_sel = 2'd3; e.pc_wr = 1'b1; end
          default: ;
        endcase
      end
      "M": begin e.state = 3'd3; e.extop = 2'd1; e.mem_wr = (kind == K_SW); end
      "W": begin
        e.state = 3'd4; e.reg_wr = 1'b1;
        case (kind)
          K_ADDU: e.reg_dst = 2'd1;
          K_SUBU: begin e.reg_dst = 2'd1; e.alu_op = 3'd1; end
          K_ORI:  begin e.alu_src = 1'b1; e.alu_op = 3'd2; end
          K_LUI:  begin e.extop = 2'd2; e.alu_src = 1'b1; end
          K_LW:   begin e.wd_sel = 2'd1; e.extop = 2'd1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  // Drive one instruction from FETCH to retirement, recording observed and
  // expected outputs per cycle. Entered #1 after a rising edge in FETCH.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input bit z);
    int kind;
    kind   = kind_of(op, fn);
    nlat   = phases_of(kind).len();
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int k = 0; k < nlat; k++) begin
      want[k] = model_cycle(kind, k, z);
      @(negedge clk);
      got[k] = sample();
      @(posedge clk);
      #1;
    end
    model_cnt = (model_cnt + 1) % (1 << CW);
    if (kind == K_ILL) model_ill = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = sample();
    tests++;
    if (o !== obs_t'('0)) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", o, obs_t'('0));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
    model_ill = 1'b0;
  endtask

  task automatic test_ori();
    exec_instr(6'b001101, 6'($urandom), 1'($urandom));
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL ori cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_lw_sw();
    exec_instr(6'b100011, 6'($urandom), 1'b0);
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL lw cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
    exec_instr(6'b101011, 6'($urandom), 1'b1);
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL sw cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_beq();
    for (int t = 1; t >= 0; t--) begin
      exec_instr(6'b000100, 6'($urandom), 1'(t));
      for (int k = 0; k < nlat; k++) begin
        tests++;
        if (got[k] !== want[k]) begin
          fails++;
          $display("FAIL beq_z%0d cyc%0d: got %h want %h", t, k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_jal_jr();
    exec_instr(6'b000011, 6'($urandom), 1'($urandom));
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL jal cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
    exec_instr(6'b000000, 6'b001000, 1'($urandom));
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL jr cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_illegal();
    exec_instr(6'b111111, 6'($urandom), 1'b0);
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL ill_op cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
    exec_instr(6'b000000, 6'b000000, 1'b0);
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL ill_funct cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  // Abort an addu in WB by asserting reset between clock edges.
  task automatic test_reset_mid();
    obs_t o;
    opcode = 6'b000000;
    funct  = 6'b100001;
    zero   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (reg_wr !== 1'b1 || state !== 3'd4) begin
      fails++;
      $display("FAIL pre_reset_wb: got reg_wr=%b state=%0d want reg_wr=1 state=4", reg_wr, state);
    end
    #2;
    reset = 1'b1;
    #1;
    o = sample();
    tests++;
    if (o !== obs_t'('0)) begin
      fails++;
      $display("FAIL reset_mid: got %h want %h", o, obs_t'('0));
    end
    model_cnt = 0;
    model_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exec_instr(6'b000000, 6'b100001, 1'b0);
    for (int k = 0; k < nlat; k++) begin
      tests++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL post_reset_addu cyc%0d: got %h want %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [3];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
            6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b000000};
    fns = '{6'b100001, 6'b100011, 6'b001000};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else fn = fns[$urandom_range(0, 2)];
      exec_instr(op, fn, 1'($urandom));
      for (int k = 0; k < nlat; k++) begin
        tests++;
        if (got[k] !== want[k]) begin
          fails++;
          $display("FAIL rand%0d op=%b fn=%b cyc%0d: got %h want %h",
                   i, op, fn, k, got[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_lw_sw();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
